reg_file: RTL and testbench
===========================

# reg_file

16 × 16-bit general-purpose register file for the CPE142 processor datapath, sitting between decode and the ALU/multiply-divide unit. It provides two combinational read ports addressed by the instruction operand fields and a dedicated always-visible R15 output. It has two synchronous write paths: a general write into the register named by `read_op1`, and a dedicated R15 write used for multiply high-half and divide remainder results.

## Interface
Parameters:
- `DATA_W`, 16, register width.
- `ADDR_W`, 4, register address width; register count is 2^ADDR_W = 16.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all writes occur on its rising edge.
- `rst`  in  1  asynchronous, active-low reset; clears every register.
- `regWrite`  in  1  general write enable.
- `read_op1`  in  4  read port 1 address; also the general write destination.
- `read_op2`  in  4  read port 2 address.
- `wrData`  in  16  general write data.
- `R15write`  in  1  dedicated R15 write enable.
- `wrR15_Data`  in  16  dedicated R15 write data.
- `op1_Out`  out  16  contents of register `read_op1`.
- `op2_Out`  out  16  contents of register `read_op2`.
- `R15_Out`  out  16  contents of R15.

## Operation
- Storage is R0–R15, each 16 bits. No register is hardwired; R0 is writable.
- Reads:
  - `op1_Out` = reg[`read_op1`], `op2_Out` = reg[`read_op2`], `R15_Out` = reg[15].
  - All three reads are purely combinational from the current register state.
- General write: on the rising edge of `clk`, if `rst`=1 and `regWrite`=1, reg[`read_op1`] ← `wrData`.
- R15 write: on the rising edge of `clk`, if `rst`=1 and `R15write`=1, reg[15] ← `wrR15_Data`.
- Both writes may occur in the same cycle to different registers.
- Collision (`regWrite`=1, `R15write`=1, `read_op1`=15): the R15 port has priority. R15 takes `wrR15_Data` and `wrData` is discarded.
- With both enables low, the state holds.
- Unknown or X on an enable must not corrupt registers in synthesis. No special simulation handling is required.

## Timing
- Reset: while `rst`=0, all 16 registers are 0 immediately, independent of `clk`. `op1_Out`, `op2_Out` and `R15_Out` read 0x0000.
- Reset deassertion: the first write is accepted on the first rising edge with `rst`=1.
- Reset asserted mid-cycle overrides any pending write.
- Write latency: 1 cycle. Data is visible on read outputs after the capturing edge.
- Read latency: 0 cycles (combinational from address change).
- Read-during-write, without bypass: in the write cycle, outputs show the old value. The new value appears after the edge.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: write-through forwarding. Any read port whose address matches an active write in the current cycle outputs the incoming data combinationally, before the edge. The same R15-port priority rule applies. `R15_Out` forwards `wrR15_Data` when `R15write`=1, or `wrData` when `regWrite`=1 with `read_op1`=15 and `R15write`=0.
- Undefined: no forwarding; behaviour as in Timing.

## Structure
- Shared package `reg_file_pkg`: `DATA_W`, `ADDR_W`, `NUM_REGS`=16, `R15_IDX`=4'd15, and the typedef `word_t` (16-bit logic).
- Natural sub-module: `reg_file_read_port`. It is a 16:1 read mux plus the optional bypass compare. It is instantiated for `op1_Out` and `op2_Out`, and with a constant address of 15 for `R15_Out`.

## Test plan
- Reset: hold `rst`=0 with random enables and data → all three outputs 0x0000 and no writes take effect. Release, read every address → 0x0000.
- General write:
  - `rst`=1, `regWrite`=1, `read_op1`=1, `wrData`=0x1010, one edge → `op1_Out`=0x1010.
  - Then `read_op2`=1 → `op2_Out`=0x1010.
  - `read_op2`=2 → 0x0000.
- R15 write: `R15write`=1, `wrR15_Data`=0x0001, edge → `R15_Out`=0x0001. Then `R15write`=0, `wrR15_Data`=0x0008, edge → `R15_Out` stays 0x0001.
- Concurrent and colliding writes:
  - `regWrite`=1, `read_op1`=3, `wrData`=0x1100, and `R15write`=1, `wrR15_Data`=0x0008, same edge → reg3=0x1100 and R15=0x0008.
  - Repeat with `read_op1`=15 and `wrData`=0xAAAA → R15=0x0008.
- Hold and read-during-write:
  - `regWrite`=0 with varying `wrData` → no change.
  - Without the macro, in the write cycle `op1_Out` shows the old value. With `REGFILE_BYPASS_EN`, it shows `wrData` before the edge.
- Async reset mid-operation: fill all registers, pulse `rst`=0 between clock edges → outputs drop to 0x0000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the 16 x 16-bit processor register file.
// Optional write-through forwarding is enabled with the REGFILE_BYPASS_EN macro.
package reg_file_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] R15_IDX = 4'd15;

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t [NUM_REGS-1:0] regs_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: 16:1 mux over the register array.
// With REGFILE_BYPASS_EN, in-flight writes are forwarded (R15 port wins over the general port).
module reg_file_read_port
    import reg_file_pkg::*;
(
    input  regs_t               i_regs,
    input  logic [ADDR_W-1:0]   i_addr,
    output word_t               o_data
`ifdef REGFILE_BYPASS_EN
    ,
    input  logic                i_rst,
    input  logic                i_regWrite,
    input  logic [ADDR_W-1:0]   i_wrAddr,
    input  word_t               i_wrData,
    input  logic                i_R15write,
    input  word_t               i_wrR15Data
`endif
);

`ifdef REGFILE_BYPASS_EN
    // Forwarding only applies to writes that will actually land, so reset masks it.
    always_comb begin
        o_data = i_regs[i_addr];
        if (i_rst && i_regWrite && (i_wrAddr == i_addr)) begin
            o_data = i_wrData;
        end
        if (i_rst && i_R15write && (i_addr == R15_IDX)) begin
            o_data = i_wrR15Data;
        end
    end
`else
    always_comb begin
        o_data = i_regs[i_addr];
    end
`endif

endmodule

// File: rtl/reg_file.sv
// 16 x 16-bit register file: two addressed read ports, an always-visible R15 output,
// a general write into read_op1 and a dedicated R15 write. Optional macro: REGFILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                regWrite,
    input  logic [ADDR_W-1:0]   read_op1,
    input  logic [ADDR_W-1:0]   read_op2,
    input  word_t               wrData,
    input  logic                R15write,
    input  word_t               wrR15_Data,
    output word_t               op1_Out,
    output word_t               op2_Out,
    output word_t               R15_Out
);

    regs_t r_regs;

    // The R15 write is applied last so it overrides a general write aimed at R15.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regs <= '0;
        end else begin
            if (regWrite) begin
                r_regs[read_op1] <= wrData;
            end
            if (R15write) begin
                r_regs[R15_IDX] <= wrR15_Data;
            end
        end
    end

    reg_file_read_port u_port_op1 (
        .i_regs      (r_regs),
        .i_addr      (read_op1),
        .o_data      (op1_Out)
`ifdef REGFILE_BYPASS_EN
        ,
        .i_rst       (rst),
        .i_regWrite  (regWrite),
        .i_wrAddr    (read_op1),
        .i_wrData    (wrData),
        .i_R15write  (R15write),
        .i_wrR15Data (wrR15_Data)
`endif
    );

    reg_file_read_port u_port_op2 (
        .i_regs      (r_regs),
        .i_addr      (read_op2),
        .o_data      (op2_Out)
`ifdef REGFILE_BYPASS_EN
        ,
        .i_rst       (rst),
        .i_regWrite  (regWrite),
        .i_wrAddr    (read_op1),
        .i_wrData    (wrData),
        .i_R15write  (R15write),
        .i_wrR15Data (wrR15_Data)
`endif
    );

    reg_file_read_port u_port_r15 (
        .i_regs      (r_regs),
        .i_addr      (R15_IDX),
        .o_data      (R15_Out)
`ifdef REGFILE_BYPASS_EN
        ,
        .i_rst       (rst),
        .i_regWrite  (regWrite),
        .i_wrAddr    (read_op1),
        .i_wrData    (wrData),
        .i_R15write  (R15write),
        .i_wrR15Data (wrR15_Data)
`endif
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed cases plus randomized traffic
// compared against an array model of the sixteen registers.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        regWrite;
    logic [3:0]  read_op1;
    logic [3:0]  read_op2;
    logic [15:0] wrData;
    logic        R15write;
    logic [15:0] wrR15_Data;
    logic [15:0] op1_Out;
    logic [15:0] op2_Out;
    logic [15:0] R15_Out;

    logic [15:0] model [16];
    int assertCount = 0;
    int failCount   = 0;

    reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .regWrite   (regWrite),
        .read_op1   (read_op1),
        .read_op2   (read_op2),
        .wrData     (wrData),
        .R15write   (R15write),
        .wrR15_Data (wrR15_Data),
        .op1_Out    (op1_Out),
        .op2_Out    (op2_Out),
        .R15_Out    (R15_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every comparison and reports any mismatch on a single line.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic [3:0] a1, input logic [3:0] a2,
                                 input logic [15:0] wd, input logic r15w, input logic [15:0] r15d);
        regWrite   = rw;
        read_op1   = a1;
        read_op2   = a2;
        wrData     = wd;
        R15write   = r15w;
        wrR15_Data = r15d;
    endtask

    // What a read of 'addr' should show right now, given stored state and current inputs.
    function automatic logic [15:0] expRead(input logic [3:0] addr);
        logic [15:0] v;
        if (!rst) return 16'h0000;
        v = model[addr];
`ifdef REGFILE_BYPASS_EN
        if (regWrite && read_op1 == addr) v = wrData;
        if (R15write && addr == 4'd15) v = wrR15_Data;
`endif
        return v;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    endtask

    // Called at a falling edge: checks outputs before and after the next rising edge.
    task automatic runCycle(input string tag);
        #1;
        checkOutput({tag, "/op1_pre"}, op1_Out, expRead(read_op1));
        checkOutput({tag, "/op2_pre"}, op2_Out, expRead(read_op2));
        checkOutput({tag, "/r15_pre"}, R15_Out, expRead(4'd15));
        @(posedge clk);
        if (rst) begin
            if (regWrite) model[read_op1] = wrData;
            if (R15write) model[15] = wrR15_Data;
        end
        #1;
        checkOutput({tag, "/op1_post"}, op1_Out, expRead(read_op1));
        checkOutput({tag, "/op2_post"}, op2_Out, expRead(read_op2));
        checkOutput({tag, "/r15_post"}, R15_Out, expRead(4'd15));
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        for (int a = 0; a < 16; a++) begin
            read_op1 = 4'(a);
            read_op2 = 4'(15 - a);
            #1;
            checkOutput({tag, "/op1"}, op1_Out, 16'h0000);
            checkOutput({tag, "/op2"}, op2_Out, 16'h0000);
        end
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0, 16'h0000, 1'b0, 16'h0000);
        clearModel();
        @(negedge clk);

        // Reset held with random write traffic: nothing may land.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
                          1'($urandom), 16'($urandom));
            runCycle("reset_hold");
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 16'h0000, 1'b0, 16'h0000);
        rst = 1'b1;
        checkAllZero("after_reset");
        @(negedge clk);

        // General write and reads through both ports.
        applyStimulus(1'b1, 4'd1, 4'd0, 16'h1010, 1'b0, 16'h0000);
        runCycle("gen_write");
        applyStimulus(1'b0, 4'd1, 4'd1, 16'h0000, 1'b0, 16'h0000);
        #1;
        checkOutput("gen_op1_const", op1_Out, 16'h1010);
        checkOutput("gen_op2_const", op2_Out, 16'h1010);
        read_op2 = 4'd2;
        #1;
        checkOutput("gen_op2_r2", op2_Out, 16'h0000);
        @(negedge clk);

        // Dedicated R15 write, then a disabled one.
        applyStimulus(1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 16'h0001);
        runCycle("r15_write");
        applyStimulus(1'b0, 4'd0, 4'd0, 16'h0000, 1'b0, 16'h0008);
        runCycle("r15_hold");
        checkOutput("r15_const", R15_Out, 16'h0001);

        // Concurrent writes, then a collision on R15.
        applyStimulus(1'b1, 4'd3, 4'd15, 16'h1100, 1'b1, 16'h0008);
        runCycle("concurrent");
        applyStimulus(1'b0, 4'd3, 4'd15, 16'h0000, 1'b0, 16'h0000);
        #1;
        checkOutput("conc_r3_const", op1_Out, 16'h1100);
        checkOutput("conc_r15_const", R15_Out, 16'h0008);
        @(negedge clk);
        applyStimulus(1'b1, 4'd15, 4'd3, 16'hAAAA, 1'b1, 16'h0008);
        runCycle("collision");
        checkOutput("coll_r15_const", R15_Out, 16'h0008);

        // Hold with changing data, then a read-during-write on a known register.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'($urandom), 4'($urandom), 16'($urandom), 1'b0, 16'($urandom));
            runCycle("hold");
        end
        applyStimulus(1'b1, 4'd1, 4'd3, 16'h5A5A, 1'b0, 16'h0000);
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("rdw_const", op1_Out, 16'h5A5A);
`else
        checkOutput("rdw_const", op1_Out, 16'h1010);
`endif
        runCycle("rdw");

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
                          1'($urandom_range(0, 3) == 0), 16'($urandom));
            runCycle("random");
        end

        // Fill every register, then pulse reset between clock edges.
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b1, 4'(a), 4'(a), 16'(16'h1000 + a * 16'h0111), 1'b0, 16'h0000);
            runCycle("fill");
        end
        applyStimulus(1'b0, 4'd5, 4'd9, 16'h0000, 1'b0, 16'h0000);
        #1;
        checkOutput("fill_op1_const", op1_Out, 16'h1555);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_op1", op1_Out, 16'h0000);
        checkOutput("async_op2", op2_Out, 16'h0000);
        checkOutput("async_r15", R15_Out, 16'h0000);
        clearModel();
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("after_async");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
